mult_rev_seq: RTL and testbench



---
 rtl/mult_rev_seq.sv | 168 ++++++++++++++++
 tb/tb_mult_rev_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rev_seq.sv
// Sequential reversible shift-add multiplier: forward (A,B)->(P,A,G), backward (P,A,G)->(A,B).
// Optional consistency checking under MULT_REV_CHECK_EN; power pins under USE_POWER_PINS.
module mult_rev_seq #(
  parameter int WIDTH = 8
) (
`ifdef USE_POWER_PINS
  inout  wire                 VDD,
  inout  wire                 VSS,
`endif
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_dir,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [2*WIDTH-1:0]  in_p,
  input  logic [WIDTH-1:0]    in_g,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_dir,
  output logic [2*WIDTH-1:0]  out_p,
  output logic [WIDTH-1:0]    out_a,
  output logic [WIDTH-1:0]    out_b,
  output logic [WIDTH-1:0]    out_g,
  output logic                out_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
`ifdef MULT_REV_CHECK_EN
  logic             err_q, err_d;
  logic             b_out;
  logic             b_borrow;
`endif

  logic             last;
  logic [CW-1:0]    j_idx;
  logic             g_j;
  logic [WIDTH:0]   f_sum;
  logic [WIDTH:0]   b_sh;
  logic [WIDTH:0]   b_sub;

  // Per-step datapath for both directions
  always_comb begin
    last  = (cnt_q == LAST);
    j_idx = LAST - cnt_q;
    g_j   = g_q[j_idx];
    f_sum = lo_q[0] ? (hi_q + {1'b0, a_q}) : hi_q;
    b_sh  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    b_sub = b_sh - {1'b0, a_q};
`ifdef MULT_REV_CHECK_EN
    b_out    = hi_q[WIDTH];
    b_borrow = (b_sh < {1'b0, a_q});
`endif
  end

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
`ifdef MULT_REV_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = in_a;
          dir_d   = in_dir;
          cnt_d   = '0;
          if (in_dir) begin
            {hi_d, lo_d} = {1'b0, in_p};
            g_d          = in_g;
`ifdef MULT_REV_CHECK_EN
            err_d        = 1'b0;
`endif
          end else begin
            hi_d = '0;
            lo_d = in_b;
            g_d  = '0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = DONE;
        if (!dir_q) begin
          g_d[cnt_q]   = lo_q[0];
          {hi_d, lo_d} = {1'b0, f_sum, lo_q[WIDTH-1:1]};
        end else begin
          lo_d = {lo_q[WIDTH-2:0], g_j};
          hi_d = g_j ? b_sub : b_sh;
`ifdef MULT_REV_CHECK_EN
          if (b_out || (g_j && b_borrow)) err_d = 1'b1;
          if (last && (hi_d != '0)) err_d = 1'b1;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

`ifdef MULT_REV_CHECK_EN
  // Consistency flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_dir   = out_valid & dir_q;
  assign out_a     = out_valid ? a_q : '0;
  assign out_p     = (out_valid && !dir_q) ? {hi_q[WIDTH-1:0], lo_q} : '0;
  assign out_g     = (out_valid && !dir_q) ? g_q : '0;
  assign out_b     = (out_valid && dir_q) ? lo_q : '0;
`ifdef MULT_REV_CHECK_EN
  assign out_err   = out_valid & dir_q & err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_rev_seq.sv
// Testbench for mult_rev_seq at WIDTH=8 and WIDTH=16.
// Reference model: P=A*B, G=B forward; B=G, err=(P!=A*G) backward.
module tb_mult_rev_seq;

`ifdef MULT_REV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk, rst_n;
  int n_cmp, n_bad;

  logic        iv8, ir8, idir8, ov8, ordy8, odir8, oerr8;
  logic [7:0]  ia8, ib8, ig8, oa8, ob8, og8;
  logic [15:0] ip8, op8;

  logic        iv16, ir16, idir16, ov16, ordy16, odir16, oerr16;
  logic [15:0] ia16, ib16, ig16, oa16, ob16, og16;
  logic [31:0] ip16, op16;

`ifdef USE_POWER_PINS
  wire pwr, gnd;
  assign pwr = 1'b1;
  assign gnd = 1'b0;
`endif

  mult_rev_seq #(.WIDTH(8)) dut8 (
`ifdef USE_POWER_PINS
    .VDD(pwr), .VSS(gnd),
`endif
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_dir(idir8),
    .in_a(ia8), .in_b(ib8), .in_p(ip8), .in_g(ig8),
    .out_valid(ov8), .out_ready(ordy8), .out_dir(odir8),
    .out_p(op8), .out_a(oa8), .out_b(ob8), .out_g(og8),
    .out_err(oerr8)
  );

  mult_rev_seq #(.WIDTH(16)) dut16 (
`ifdef USE_POWER_PINS
    .VDD(pwr), .VSS(gnd),
`endif
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_dir(idir16),
    .in_a(ia16), .in_b(ib16), .in_p(ip16), .in_g(ig16),
    .out_valid(ov16), .out_ready(ordy16), .out_dir(odir16),
    .out_p(op16), .out_a(oa16), .out_b(ob16), .out_g(og16),
    .out_err(oerr16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic xact8(
    input  logic        d,
    input  logic [7:0]  a, b,
    input  logic [15:0] p,
    input  logic [7:0]  g,
    output int          lat,
    output logic [15:0] rp,
    output logic [7:0]  ra, rb, rg,
    output logic        re, rd
  );
    int t;
    t = 0;
    while (ir8 !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    idir8 = d; ia8 = a; ib8 = b; ip8 = p; ig8 = g;
    iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    ia8 = 8'($urandom); ib8 = 8'($urandom);
    ip8 = 16'($urandom); ig8 = 8'($urandom);
    lat = 0;
    while (ov8 !== 1'b1 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    rp = op8; ra = oa8; rb = ob8; rg = og8;
    re = oerr8; rd = odir8;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
  endtask

  task automatic xact16(
    input  logic        d,
    input  logic [15:0] a, b,
    input  logic [31:0] p,
    input  logic [15:0] g,
    output int          lat,
    output logic [31:0] rp,
    output logic [15:0] ra, rb, rg,
    output logic        re, rd
  );
    int t;
    t = 0;
    while (ir16 !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    idir16 = d; ia16 = a; ib16 = b; ip16 = p; ig16 = g;
    iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    ia16 = 16'($urandom); ib16 = 16'($urandom);
    lat = 0;
    while (ov16 !== 1'b1 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    rp = op16; ra = oa16; rb = ob16; rg = og16;
    re = oerr16; rd = odir16;
    ordy16 = 1'b1;
    @(posedge clk); #1;
    ordy16 = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if (ir8 !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready8 got=%b exp=1", ir8);
    end
    n_cmp++;
    if ({ov8, odir8, op8, oa8, ob8, og8, oerr8} !== '0) begin
      n_bad++;
      $display("FAIL rst_out8 got v=%b p=%h a=%h b=%h g=%h e=%b exp all 0",
               ov8, op8, oa8, ob8, og8, oerr8);
    end
    n_cmp++;
    if (ir16 !== 1'b1 || {ov16, odir16, op16, oa16, ob16, og16, oerr16} !== '0) begin
      n_bad++;
      $display("FAIL rst_16 got rdy=%b v=%b p=%h exp rdy=1 rest 0",
               ir16, ov16, op16);
    end
  endtask

  task automatic test_forward;
    logic [7:0] da[4] = '{8'h0D, 8'h00, 8'hFF, 8'h01};
    logic [7:0] db[4] = '{8'h0B, 8'hFF, 8'hFF, 8'h80};
    logic [7:0] a, b, ra, rb, rg;
    logic [15:0] rp, ep;
    logic re, rd;
    int lat;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) begin
        a = da[i]; b = db[i];
      end else begin
        a = 8'($urandom); b = 8'($urandom);
      end
      xact8(1'b0, a, b, 16'($urandom), 8'($urandom),
            lat, rp, ra, rb, rg, re, rd);
      ep = {8'h00, a} * {8'h00, b};
      n_cmp++;
      if (lat !== 8) begin
        n_bad++; $display("FAIL fwd_lat a=%h b=%h got=%0d exp=8", a, b, lat);
      end
      n_cmp++;
      if (rp !== ep) begin
        n_bad++; $display("FAIL fwd_p a=%h b=%h got=%h exp=%h", a, b, rp, ep);
      end
      n_cmp++;
      if (ra !== a || rg !== b) begin
        n_bad++;
        $display("FAIL fwd_ag a=%h b=%h got a=%h g=%h exp a=%h g=%h",
                 a, b, ra, rg, a, b);
      end
      n_cmp++;
      if ({rb, re, rd} !== '0) begin
        n_bad++;
        $display("FAIL fwd_zero a=%h b=%h got b=%h e=%b d=%b exp 0",
                 a, b, rb, re, rd);
      end
    end
  endtask

  task automatic test_backward;
    logic [15:0] dp[3] = '{16'h008F, 16'h0090, 16'h0000};
    logic [7:0]  da[3] = '{8'h0D, 8'h0D, 8'h00};
    logic [7:0]  dg[3] = '{8'h0B, 8'h0B, 8'hFF};
    logic [7:0] a, g, ra, rb, rg;
    logic [15:0] p, rp;
    logic re, rd, ee;
    int lat;
    for (int i = 0; i < 19; i++) begin
      if (i < 3) begin
        p = dp[i]; a = da[i]; g = dg[i];
      end else if (i < 11) begin
        a = 8'($urandom); g = 8'($urandom);
        p = {8'h00, a} * {8'h00, g};
      end else begin
        a = 8'($urandom); g = 8'($urandom);
        p = 16'($urandom);
      end
      xact8(1'b1, a, 8'($urandom), p, g, lat, rp, ra, rb, rg, re, rd);
      ee = CHK && (p != {8'h00, a} * {8'h00, g});
      n_cmp++;
      if (lat !== 8) begin
        n_bad++; $display("FAIL bwd_lat p=%h got=%0d exp=8", p, lat);
      end
      n_cmp++;
      if (rb !== g || ra !== a) begin
        n_bad++;
        $display("FAIL bwd_ab p=%h a=%h g=%h got b=%h a=%h exp b=%h a=%h",
                 p, a, g, rb, ra, g, a);
      end
      n_cmp++;
      if (re !== ee) begin
        n_bad++;
        $display("FAIL bwd_err p=%h a=%h g=%h got=%b exp=%b", p, a, g, re, ee);
      end
      n_cmp++;
      if (rp !== '0 || rg !== '0 || rd !== 1'b1) begin
        n_bad++;
        $display("FAIL bwd_misc got p=%h g=%h d=%b exp p=0 g=0 d=1", rp, rg, rd);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a1, b1, a2, b2;
    logic [15:0] snap_p;
    logic [7:0] snap_a, snap_g;
    int t, lat;
    a1 = 8'h5A; b1 = 8'hC3;
    a2 = 8'($urandom); b2 = 8'($urandom);
    t = 0;
    while (ir8 !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    idir8 = 1'b0; ia8 = a1; ib8 = b1; iv8 = 1'b1;
    @(posedge clk); #1;
    ia8 = a2; ib8 = b2;
    t = 0;
    while (ov8 !== 1'b1 && t < 64) begin
      @(posedge clk); #1; t++;
    end
    snap_p = op8; snap_a = oa8; snap_g = og8;
    n_cmp++;
    if (snap_p !== {8'h00, a1} * {8'h00, b1}) begin
      n_bad++;
      $display("FAIL b2b_first got=%h exp=%h", snap_p, {8'h00, a1} * {8'h00, b1});
    end
    for (int c = 0; c < 5; c++) begin
      idir8 = 1'($urandom); ia8 = 8'($urandom); ib8 = 8'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (ov8 !== 1'b1 || op8 !== snap_p || oa8 !== snap_a || og8 !== snap_g) begin
        n_bad++;
        $display("FAIL b2b_hold c=%0d got v=%b p=%h a=%h g=%h exp v=1 p=%h a=%h g=%h",
                 c, ov8, op8, oa8, og8, snap_p, snap_a, snap_g);
      end
      n_cmp++;
      if (ir8 !== 1'b0) begin
        n_bad++; $display("FAIL b2b_rdy c=%0d got=%b exp=0", c, ir8);
      end
    end
    idir8 = 1'b0; ia8 = a2; ib8 = b2;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
    n_cmp++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_idle got v=%b rdy=%b exp v=0 rdy=1", ov8, ir8);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    n_cmp++;
    if (ir8 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_accept got rdy=%b exp=0", ir8);
    end
    lat = 0;
    while (ov8 !== 1'b1 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (lat !== 8 || op8 !== {8'h00, a2} * {8'h00, b2}) begin
      n_bad++;
      $display("FAIL b2b_second got lat=%0d p=%h exp lat=8 p=%h",
               lat, op8, {8'h00, a2} * {8'h00, b2});
    end
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] ra, rb, rg;
    logic [15:0] rp;
    logic re, rd, seen;
    int t, lat;
    t = 0;
    while (ir8 !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    idir8 = 1'b0; ia8 = 8'h77; ib8 = 8'h99; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov8, odir8, op8, oa8, ob8, og8, oerr8} !== '0 || ir8 !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_out got v=%b p=%h a=%h rdy=%b exp 0 with rdy=1",
               ov8, op8, oa8, ir8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (ir8 !== 1'b1) begin
      n_bad++; $display("FAIL midrst_rdy got=%b exp=1", ir8);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov8 !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL midrst_drop got out_valid=1 exp=0");
    end
    xact8(1'b0, 8'h0D, 8'h0B, 16'h0, 8'h0, lat, rp, ra, rb, rg, re, rd);
    n_cmp++;
    if (lat !== 8 || rp !== 16'h008F || rg !== 8'h0B) begin
      n_bad++;
      $display("FAIL midrst_next got lat=%0d p=%h g=%h exp lat=8 p=008f g=0b",
               lat, rp, rg);
    end
  endtask

  task automatic test_w16;
    logic [15:0] a, b, ra, rb, rg;
    logic [31:0] rp, ep;
    logic re, rd;
    int lat;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        a = 16'hFFFF; b = 16'hFFFF;
      end else begin
        a = 16'($urandom); b = 16'($urandom);
      end
      ep = {16'h0, a} * {16'h0, b};
      xact16(1'b0, a, b, 32'($urandom), 16'($urandom),
             lat, rp, ra, rb, rg, re, rd);
      n_cmp++;
      if (lat !== 16 || rp !== ep || rg !== b || ra !== a) begin
        n_bad++;
        $display("FAIL w16_fwd a=%h b=%h got lat=%0d p=%h g=%h exp lat=16 p=%h g=%h",
                 a, b, lat, rp, rg, ep, b);
      end
      xact16(1'b1, a, 16'($urandom), ep, b, lat, rp, ra, rb, rg, re, rd);
      n_cmp++;
      if (lat !== 16 || rb !== b || re !== 1'b0 || ra !== a) begin
        n_bad++;
        $display("FAIL w16_bwd a=%h got lat=%0d b=%h e=%b exp lat=16 b=%h e=0",
                 a, lat, rb, re, b);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    iv8 = 0; idir8 = 0; ia8 = 0; ib8 = 0; ip8 = 0; ig8 = 0; ordy8 = 0;
    iv16 = 0; idir16 = 0; ia16 = 0; ib16 = 0; ip16 = 0; ig16 = 0; ordy16 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_forward();
    test_backward();
    test_back_to_back();
    test_reset_mid();
    test_w16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
